// File: rtl/display_menu_ctrl.sv
// On-screen menu controller: debounced buttons drive a HIDDEN/MAIN/ADJUST menu;
// the renderer sees a shadow copy of the working registers, refreshed only on frame_tick.
module display_menu_ctrl #(
  parameter int SCROLL_MAX  = 1279,
  parameter int SCROLL_STEP = 2
) (
  input  logic        CLK_VGA,
  input  logic        RESET,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  input  logic        btn_back,
  input  logic        frame_tick,
  output logic [1:0]  Color_Scheme,
  output logic        Axis_On,
  output logic        Grid_On,
  output logic        Tick_On,
  output logic        menu_visible,
  output logic [2:0]  cursor_index,
  output logic        adjust_active,
  output logic [10:0] scroll_offset
);

  typedef enum logic [1:0] {HIDDEN = 2'd0, MAIN = 2'd1, ADJUST = 2'd2} state_t;

  localparam logic [11:0] STEP12 = 12'(SCROLL_STEP);
  localparam logic [11:0] MAX12  = 12'(SCROLL_MAX);

  logic [3:0] btn_s, btn_r, btn_prev_r, rise_s;
  logic       primed_r;
  logic       ev_back_s, ev_sel_s, ev_up_s, ev_down_s;

  state_t     state_r, state_s;
  logic [2:0] cursor_r, cursor_s;
  logic [1:0] scheme_r, scheme_s, pending_r, pending_s;
  logic       axis_r, axis_s, grid_r, grid_s, tick_r, tick_s, scroll_en_r, scroll_en_s;
  logic [11:0] scroll_sum_s, scroll_wrap_s;

  assign btn_s = {btn_back, btn_sel, btn_up, btn_down};

  // Button history; the first sample after reset primes both stages so a held button is not an edge.
  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      btn_r      <= 4'd0;
      btn_prev_r <= 4'd0;
      primed_r   <= 1'b0;
    end else if (!primed_r) begin
      btn_r      <= btn_s;
      btn_prev_r <= btn_s;
      primed_r   <= 1'b1;
    end else begin
      btn_r      <= btn_s;
      btn_prev_r <= btn_r;
    end
  end

  // Rising-edge events with back > sel > up > down priority.
  always_comb begin
    rise_s    = btn_r & ~btn_prev_r;
    ev_back_s = rise_s[3];
    ev_sel_s  = rise_s[2] & ~rise_s[3];
    ev_up_s   = rise_s[1] & ~(|rise_s[3:2]);
    ev_down_s = rise_s[0] & ~(|rise_s[3:1]);
  end

  // Menu state and working registers.
  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      state_r     <= HIDDEN;
      cursor_r    <= 3'd0;
      scheme_r    <= 2'd0;
      pending_r   <= 2'd0;
      axis_r      <= 1'b1;
      grid_r      <= 1'b1;
      tick_r      <= 1'b1;
      scroll_en_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cursor_r    <= cursor_s;
      scheme_r    <= scheme_s;
      pending_r   <= pending_s;
      axis_r      <= axis_s;
      grid_r      <= grid_s;
      tick_r      <= tick_s;
      scroll_en_r <= scroll_en_s;
    end
  end

  // Next-state and working-register update.
  always_comb begin
    state_s     = state_r;
    cursor_s    = cursor_r;
    scheme_s    = scheme_r;
    pending_s   = pending_r;
    axis_s      = axis_r;
    grid_s      = grid_r;
    tick_s      = tick_r;
    scroll_en_s = scroll_en_r;
    case (state_r)
      HIDDEN: begin
        if (ev_sel_s) begin
          state_s  = MAIN;
          cursor_s = 3'd0;
        end else begin
          state_s = HIDDEN;
        end
      end
      MAIN: begin
        if (ev_back_s) begin
          state_s = HIDDEN;
        end else if (ev_sel_s) begin
          case (cursor_r)
            3'd0: axis_s      = ~axis_r;
            3'd1: grid_s      = ~grid_r;
            3'd2: tick_s      = ~tick_r;
            3'd3: begin
              state_s   = ADJUST;
              pending_s = scheme_r;
            end
            3'd4: scroll_en_s = ~scroll_en_r;
            default: cursor_s = 3'd0;
          endcase
        end else if (ev_up_s) begin
          cursor_s = (cursor_r == 3'd0) ? 3'd4 : cursor_r - 3'd1;
        end else if (ev_down_s) begin
          cursor_s = (cursor_r >= 3'd4) ? 3'd0 : cursor_r + 3'd1;
        end else begin
          state_s = MAIN;
        end
      end
      ADJUST: begin
        if (ev_back_s) begin
          state_s = MAIN;
        end else if (ev_sel_s) begin
          scheme_s = pending_r;
          state_s  = MAIN;
        end else if (ev_up_s) begin
          pending_s = pending_r + 2'd1;
        end else if (ev_down_s) begin
          pending_s = pending_r - 2'd1;
        end else begin
          state_s = ADJUST;
        end
      end
      default: state_s = HIDDEN;
    endcase
  end

  // 12-bit scroll sum so the wrap compare cannot overflow.
  always_comb begin
    scroll_sum_s = {1'b0, scroll_offset} + STEP12;
    if (scroll_sum_s > MAX12) begin
      scroll_wrap_s = scroll_sum_s - MAX12 - 12'd1;
    end else begin
      scroll_wrap_s = scroll_sum_s;
    end
  end

  // Shadow commit: outputs follow the pre-edge working values only on frame_tick.
  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      Color_Scheme  <= 2'd0;
      Axis_On       <= 1'b1;
      Grid_On       <= 1'b1;
      Tick_On       <= 1'b1;
      menu_visible  <= 1'b0;
      cursor_index  <= 3'd0;
      adjust_active <= 1'b0;
      scroll_offset <= 11'd0;
    end else if (frame_tick) begin
      Color_Scheme  <= (state_r == ADJUST) ? pending_r : scheme_r;
      Axis_On       <= axis_r;
      Grid_On       <= grid_r;
      Tick_On       <= tick_r;
      menu_visible  <= (state_r != HIDDEN);
      cursor_index  <= cursor_r;
      adjust_active <= (state_r == ADJUST);
      if (scroll_en_r) begin
        scroll_offset <= 11'(scroll_wrap_s);
      end
    end
  end

endmodule

// File: tb/tb_display_menu_ctrl.sv
// Directed bench for display_menu_ctrl with hand-computed expectations.
module tb_display_menu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0, btn_back = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  color_scheme;
  logic        axis_on, grid_on, tick_on, menu_visible, adjust_active;
  logic [2:0]  cursor_index;
  logic [10:0] scroll_offset;

  int tests = 0;
  int fails = 0;

  display_menu_ctrl #(.SCROLL_MAX(1279), .SCROLL_STEP(2)) dut (
    .CLK_VGA(clk), .RESET(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel), .btn_back(btn_back),
    .frame_tick(frame_tick),
    .Color_Scheme(color_scheme), .Axis_On(axis_on), .Grid_On(grid_on), .Tick_On(tick_on),
    .menu_visible(menu_visible), .cursor_index(cursor_index),
    .adjust_active(adjust_active), .scroll_offset(scroll_offset)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mask bits: {back, sel, up, down}
  task automatic press(input logic [3:0] mask);
    {btn_back, btn_sel, btn_up, btn_down} = mask;
    tick(1);
    {btn_back, btn_sel, btn_up, btn_down} = 4'b0000;
    tick(3);
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    tick(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".color"},  16'(color_scheme),  16'd0);
    check({tag, ".axis"},   16'(axis_on),       16'd1);
    check({tag, ".grid"},   16'(grid_on),       16'd1);
    check({tag, ".tick"},   16'(tick_on),       16'd1);
    check({tag, ".menu"},   16'(menu_visible),  16'd0);
    check({tag, ".cursor"}, 16'(cursor_index),  16'd0);
    check({tag, ".adjust"}, 16'(adjust_active), 16'd0);
    check({tag, ".scroll"}, 16'(scroll_offset), 16'd0);
  endtask

  localparam logic [3:0] B_BACK = 4'b1000;
  localparam logic [3:0] B_SEL  = 4'b0100;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0001;

  initial begin
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(2);

    // open menu: invisible until a frame_tick commits it
    press(B_SEL);
    check("no_tick_menu", 16'(menu_visible), 16'd0);
    frame();
    check("open_menu", 16'(menu_visible), 16'd1);
    check("open_cursor", 16'(cursor_index), 16'd0);

    // cursor wrap
    press(B_UP);
    frame();
    check("cursor_wrap_up", 16'(cursor_index), 16'd4);
    press(B_DOWN);
    press(B_DOWN);
    frame();
    check("cursor_down2", 16'(cursor_index), 16'd1);

    // colour edit with live preview, discard, then commit
    press(B_DOWN);
    press(B_DOWN);
    press(B_SEL);
    press(B_UP);
    press(B_UP);
    frame();
    check("adj_active", 16'(adjust_active), 16'd1);
    check("adj_preview", 16'(color_scheme), 16'd2);
    press(B_BACK);
    frame();
    check("adj_discard_color", 16'(color_scheme), 16'd0);
    check("adj_discard_active", 16'(adjust_active), 16'd0);
    press(B_SEL);
    press(B_UP);
    press(B_UP);
    press(B_SEL);
    frame();
    check("adj_commit_color", 16'(color_scheme), 16'd2);
    check("adj_commit_active", 16'(adjust_active), 16'd0);
    check("adj_commit_cursor", 16'(cursor_index), 16'd3);

    // toggle axis on row 0
    press(B_UP);
    press(B_UP);
    press(B_UP);
    press(B_SEL);
    frame();
    check("axis_toggle", 16'(axis_on), 16'd0);
    check("grid_untouched", 16'(grid_on), 16'd1);

    // back and sel together: back wins, no toggle
    press(B_BACK | B_SEL);
    frame();
    check("both_menu", 16'(menu_visible), 16'd0);
    check("both_axis", 16'(axis_on), 16'd0);

    // event landing on a frame_tick cycle commits the pre-event view
    btn_sel = 1'b1;
    tick(1);
    btn_sel = 1'b0;
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    check("same_tick_pre", 16'(menu_visible), 16'd0);
    tick(2);
    frame();
    check("same_tick_post", 16'(menu_visible), 16'd1);

    // scroll: enable on row 4, run to the wrap boundary
    press(B_UP);
    press(B_SEL);
    for (int i = 0; i < 638; i++) frame();
    check("scroll_1276", 16'(scroll_offset), 16'd1276);
    frame();
    check("scroll_1278", 16'(scroll_offset), 16'd1278);
    frame();
    check("scroll_wrap", 16'(scroll_offset), 16'd0);
    frame();
    check("scroll_2", 16'(scroll_offset), 16'd2);
    press(B_SEL);
    frame();
    check("scroll_hold", 16'(scroll_offset), 16'd2);
    tick(5);
    check("scroll_no_tick", 16'(scroll_offset), 16'd2);

    // ADJUST with pending 3, then asynchronous reset while sel is held
    press(B_UP);
    press(B_SEL);
    press(B_UP);
    frame();
    check("pre_rst_color", 16'(color_scheme), 16'd3);
    check("pre_rst_adjust", 16'(adjust_active), 16'd1);
    btn_sel = 1'b1;
    rst = 1'b1;
    #2;
    check_reset_vals("async_rst");
    tick(3);
    rst = 1'b0;
    tick(4);
    frame();
    check("held_sel_menu", 16'(menu_visible), 16'd0);
    btn_sel = 1'b0;
    tick(2);
    press(B_SEL);
    frame();
    check("repress_menu", 16'(menu_visible), 16'd1);
    check("repress_color", 16'(color_scheme), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
